// File: rtl/keystone_coeff_sync.sv
// rtl/keystone_coeff_sync.sv - frame-synchronous homography coefficient bank swap, soft reset and frame/line counters
module keystone_coeff_sync #(
    parameter int DATA_W    = 32,
    parameter int FRAC_BITS = 16,
    parameter int LINE_W    = 12,
    parameter int RST_HOLD  = 4
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              aclken,
    input  logic              cfg_wr_en,
    input  logic [2:0]        cfg_wr_addr,
    input  logic [DATA_W-1:0] cfg_wr_data,
    input  logic              cfg_commit,
    input  logic              cfg_enable,
    input  logic              sw_reset,
    input  logic              mon_tvalid,
    input  logic              mon_tready,
    input  logic              mon_tuser,
    input  logic              mon_tlast,
    output logic [DATA_W-1:0] H11,
    output logic [DATA_W-1:0] H12,
    output logic [DATA_W-1:0] H13,
    output logic [DATA_W-1:0] H21,
    output logic [DATA_W-1:0] H22,
    output logic [DATA_W-1:0] H23,
    output logic [DATA_W-1:0] H31,
    output logic [DATA_W-1:0] H32,
    output logic              enable_active,
    output logic              dp_sw_reset,
    output logic              commit_pending,
    output logic              update_done,
    output logic [15:0]       frame_count,
    output logic [LINE_W-1:0] line_count
);

    localparam int CNT_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [DATA_W-1:0] ONE = {{(DATA_W-1){1'b0}}, 1'b1} << FRAC_BITS;

    typedef enum logic [1:0] {IDLE, ARMED, SRST} state_t;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  stage_q  [8];
    logic [DATA_W-1:0]  active_q [8];
    logic               sw_prev_q;
    logic               pending_q, pending_d;
    logic               upd_q, upd_d;
    logic               dp_q, dp_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               en_q;
    logic [15:0]        frame_q;
    logic [LINE_W-1:0]  line_q;
    logic               swap, run;

    logic beat, sof, eol, sw_rise;
    assign beat    = aclken & mon_tvalid & mon_tready;
    assign sof     = beat & mon_tuser;
    assign eol     = beat & mon_tlast;
    assign sw_rise = aclken & sw_reset & ~sw_prev_q;

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q <= IDLE;
        end else if (aclken) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (sw_rise) begin
            state_d = SRST;
        end else begin
            case (state_q)
                IDLE:    if (cfg_commit) state_d = ARMED;
                ARMED:   if (sof) state_d = IDLE;
                SRST:    if (cnt_q == '0) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // run=0 freezes counters at zero and masks sof for the whole soft-reset window
    always_comb begin
        swap      = 1'b0;
        run       = 1'b1;
        pending_d = pending_q;
        upd_d     = 1'b0;
        dp_d      = 1'b0;
        cnt_d     = cnt_q;
        if (sw_rise) begin
            run       = 1'b0;
            pending_d = 1'b0;
            dp_d      = 1'b1;
            cnt_d     = CNT_W'(RST_HOLD - 1);
        end else begin
            case (state_q)
                IDLE: pending_d = cfg_commit;
                ARMED: begin
                    if (sof) begin
                        swap      = 1'b1;
                        pending_d = 1'b0;
                        upd_d     = 1'b1;
                    end
                end
                SRST: begin
                    run       = 1'b0;
                    pending_d = 1'b0;
                    if (cnt_q != '0) begin
                        dp_d  = 1'b1;
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: pending_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            for (int i = 0; i < 8; i++) begin
                stage_q[i]  <= (i == 0 || i == 4) ? ONE : '0;
                active_q[i] <= (i == 0 || i == 4) ? ONE : '0;
            end
            sw_prev_q <= 1'b0;
            pending_q <= 1'b0;
            upd_q     <= 1'b0;
            dp_q      <= 1'b0;
            cnt_q     <= '0;
            en_q      <= 1'b0;
            frame_q   <= '0;
            line_q    <= '0;
        end else if (aclken) begin
            // active copies the pre-edge staging, so a same-cycle write stays staging-only
            if (swap) active_q <= stage_q;
            if (cfg_wr_en) stage_q[cfg_wr_addr] <= cfg_wr_data;
            sw_prev_q <= sw_reset;
            pending_q <= pending_d;
            upd_q     <= upd_d;
            dp_q      <= dp_d;
            cnt_q     <= cnt_d;
            if (!run) begin
                frame_q <= '0;
                line_q  <= '0;
            end else if (sof) begin
                frame_q <= frame_q + 16'd1;
                line_q  <= LINE_W'(eol);
                en_q    <= cfg_enable;
            end else if (eol) begin
                line_q  <= line_q + LINE_W'(1);
            end
        end
    end

    assign H11            = active_q[0];
    assign H12            = active_q[1];
    assign H13            = active_q[2];
    assign H21            = active_q[3];
    assign H22            = active_q[4];
    assign H23            = active_q[5];
    assign H31            = active_q[6];
    assign H32            = active_q[7];
    assign enable_active  = en_q;
    assign dp_sw_reset    = dp_q;
    assign commit_pending = pending_q;
    assign update_done    = upd_q;
    assign frame_count    = frame_q;
    assign line_count     = line_q;

endmodule

// File: tb/tb_keystone_coeff_sync.sv
// tb/tb_keystone_coeff_sync.sv - directed bench with cycle-level reference model for keystone_coeff_sync
module tb_keystone_coeff_sync;

    localparam int RST_HOLD = 4;
    localparam logic [31:0] ONE = 32'h0001_0000;

    logic        aclk = 1'b0;
    logic        areset, aclken, cfg_wr_en, cfg_commit, cfg_enable, sw_reset;
    logic [2:0]  cfg_wr_addr;
    logic [31:0] cfg_wr_data;
    logic        mon_tvalid, mon_tready, mon_tuser, mon_tlast;
    logic [31:0] dut_h [8];
    logic        enable_active, dp_sw_reset, commit_pending, update_done;
    logic [15:0] frame_count;
    logic [11:0] line_count;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 1'b0;

    always #5 aclk = ~aclk;

    keystone_coeff_sync #(.DATA_W(32), .FRAC_BITS(16), .LINE_W(12), .RST_HOLD(RST_HOLD)) dut (
        .aclk(aclk), .areset(areset), .aclken(aclken),
        .cfg_wr_en(cfg_wr_en), .cfg_wr_addr(cfg_wr_addr), .cfg_wr_data(cfg_wr_data),
        .cfg_commit(cfg_commit), .cfg_enable(cfg_enable), .sw_reset(sw_reset),
        .mon_tvalid(mon_tvalid), .mon_tready(mon_tready), .mon_tuser(mon_tuser), .mon_tlast(mon_tlast),
        .H11(dut_h[0]), .H12(dut_h[1]), .H13(dut_h[2]), .H21(dut_h[3]),
        .H22(dut_h[4]), .H23(dut_h[5]), .H31(dut_h[6]), .H32(dut_h[7]),
        .enable_active(enable_active), .dp_sw_reset(dp_sw_reset),
        .commit_pending(commit_pending), .update_done(update_done),
        .frame_count(frame_count), .line_count(line_count)
    );

    // Reference: soft reset modelled as a remaining-cycles count, banks as plain arrays
    logic [31:0] m_stage [8];
    logic [31:0] m_active [8];
    logic        m_pend, m_upd, m_en, m_sw_prev;
    int          m_left;
    logic [15:0] m_frame;
    logic [11:0] m_line;

    always @(posedge aclk) begin
        if (areset) begin
            for (int i = 0; i < 8; i++) begin
                m_stage[i]  = (i == 0 || i == 4) ? ONE : 32'h0;
                m_active[i] = m_stage[i];
            end
            m_pend = 0; m_upd = 0; m_en = 0; m_sw_prev = 0; m_left = 0;
            m_frame = 0; m_line = 0;
        end else if (aclken) begin
            bit b, s, e, r;
            b = mon_tvalid && mon_tready;
            s = b && mon_tuser;
            e = b && mon_tlast;
            r = sw_reset && !m_sw_prev;
            m_sw_prev = sw_reset;
            m_upd = 0;
            if (r) begin
                m_left = RST_HOLD; m_pend = 0; m_frame = 0; m_line = 0;
            end else if (m_left > 0) begin
                m_left--; m_frame = 0; m_line = 0;
            end else begin
                if (s && m_pend) begin
                    m_active = m_stage; m_pend = 0; m_upd = 1;
                end else if (!m_pend && cfg_commit) begin
                    m_pend = 1;
                end
                if (s) begin
                    m_frame = m_frame + 1; m_line = e ? 12'd1 : 12'd0; m_en = cfg_enable;
                end else if (e) begin
                    m_line = m_line + 1;
                end
            end
            if (cfg_wr_en) m_stage[cfg_wr_addr] = cfg_wr_data;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
        end
    endtask

    always @(negedge aclk) begin
        if (chk_on) begin
            for (int i = 0; i < 8; i++) check($sformatf("model_H[%0d]", i), dut_h[i], m_active[i]);
            check("model_enable", 32'(enable_active), 32'(m_en));
            check("model_dp_sw_reset", 32'(dp_sw_reset), 32'(m_left > 0));
            check("model_pending", 32'(commit_pending), 32'(m_pend));
            check("model_update_done", 32'(update_done), 32'(m_upd));
            check("model_frame", 32'(frame_count), 32'(m_frame));
            check("model_line", 32'(line_count), 32'(m_line));
        end
    end

    task automatic idle();
        cfg_wr_en = 0; cfg_wr_addr = 0; cfg_wr_data = 0; cfg_commit = 0;
        sw_reset = 0; mon_tvalid = 0; mon_tready = 0; mon_tuser = 0; mon_tlast = 0;
        aclken = 1;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge aclk);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        cfg_wr_en = 1; cfg_wr_addr = a; cfg_wr_data = d;
        step(1); idle();
    endtask

    task automatic beat(input logic rdy, input logic user, input logic last);
        mon_tvalid = 1; mon_tready = rdy; mon_tuser = user; mon_tlast = last;
        step(1); idle();
    endtask

    initial begin
        int dp_cycles;
        idle();
        cfg_enable = 0;
        areset = 1;
        step(2);
        areset = 0;
        chk_on = 1;
        step(1);
        check("rst_H11", dut_h[0], 32'h0001_0000);
        check("rst_H22", dut_h[4], 32'h0001_0000);
        check("rst_H13", dut_h[2], 32'h0);
        check("rst_enable", 32'(enable_active), 32'h0);
        check("rst_frame", 32'(frame_count), 32'h0);

        wr(3'd2, 32'h0005_0000);
        cfg_commit = 1; step(1); idle();
        step(3);
        check("arm_pending", 32'(commit_pending), 32'h1);
        check("arm_H13_old", dut_h[2], 32'h0);
        cfg_enable = 1;
        beat(1, 1, 0);
        check("swap_H13", dut_h[2], 32'h0005_0000);
        check("swap_update_done", 32'(update_done), 32'h1);
        check("swap_pending", 32'(commit_pending), 32'h0);
        check("swap_frame", 32'(frame_count), 32'h1);
        check("swap_enable", 32'(enable_active), 32'h1);
        step(1);
        check("update_done_pulse", 32'(update_done), 32'h0);

        wr(3'd0, 32'h0002_0000);
        cfg_commit = 1; mon_tvalid = 1; mon_tready = 1; mon_tuser = 1;
        step(1); idle();
        check("same_cycle_no_swap", dut_h[0], 32'h0001_0000);
        check("same_cycle_pending", 32'(commit_pending), 32'h1);
        step(2);
        cfg_wr_en = 1; cfg_wr_addr = 3'd5; cfg_wr_data = 32'h0000_0099;
        beat(1, 1, 0);
        check("next_sof_swap", dut_h[0], 32'h0002_0000);
        check("swap_cycle_write_staging_only", dut_h[5], 32'h0);

        wr(3'd1, 32'h0000_0003);
        cfg_commit = 1; step(1); idle();
        beat(0, 1, 0);
        check("stall_no_swap", dut_h[1], 32'h0);
        check("stall_no_count", 32'(frame_count), 32'd3);
        beat(1, 1, 0);
        check("ready_swap", dut_h[1], 32'h0000_0003);
        check("ready_count", 32'(frame_count), 32'd4);

        wr(3'd4, 32'h0000_0007);
        cfg_commit = 1; step(1); idle();
        check("srst_pre_pending", 32'(commit_pending), 32'h1);
        sw_reset = 1; step(1); sw_reset = 0;
        dp_cycles = 0;
        for (int i = 0; i < 10; i++) begin
            if (dp_sw_reset) dp_cycles++;
            if (i == 1) begin
                check("srst_pending_cleared", 32'(commit_pending), 32'h0);
                check("srst_frame_zero", 32'(frame_count), 32'h0);
            end
            step(1);
        end
        check("srst_dp_cycles", 32'(dp_cycles), 32'd4);
        beat(1, 1, 0);
        check("srst_no_swap", dut_h[4], 32'h0001_0000);
        check("srst_frame_restart", 32'(frame_count), 32'd1);

        beat(1, 1, 0);
        beat(1, 0, 1);
        beat(1, 0, 1);
        beat(1, 0, 1);
        check("eol_lines", 32'(line_count), 32'd3);
        aclken = 0; mon_tvalid = 1; mon_tready = 1; mon_tlast = 1; mon_tuser = 1;
        step(3);
        check("clken_hold_line", 32'(line_count), 32'd3);
        check("clken_hold_frame", 32'(frame_count), 32'd2);
        idle();
        beat(1, 1, 1);
        check("sof_eol_line", 32'(line_count), 32'd1);
        step(2);

        chk_on = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
